// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage.
// The upstream pipeline drives through the master modport; ex_stage connects through the slave modport.
interface ex_stage_if;
  logic        flush_EX;
  logic        valid_ex;
  logic [2:0]  ALU_FUN;
  logic        SEL_ALU;
  logic        SEL_REG;
  logic [2:0]  ctrl_MEM_exe;
  logic [1:0]  ctrl_WB_exe;
  logic [31:0] A;
  logic [31:0] DOB_exe;
  logic [31:0] imm_ext_exe;
  logic [4:0]  rt_exe;
  logic [4:0]  rd_exe;
  logic        stall_EX;
  logic [31:0] ALU_res_mem;
  logic [31:0] DOB_mem;
  logic [4:0]  dest_mem;
  logic [2:0]  ctrl_MEM_mem;
  logic [1:0]  ctrl_WB_mem;
  logic        valid_mem;

  modport master (
    output flush_EX, valid_ex, ALU_FUN, SEL_ALU, SEL_REG, ctrl_MEM_exe, ctrl_WB_exe,
           A, DOB_exe, imm_ext_exe, rt_exe, rd_exe,
    input  stall_EX, ALU_res_mem, DOB_mem, dest_mem, ctrl_MEM_mem, ctrl_WB_mem, valid_mem
  );

  modport slave (
    input  flush_EX, valid_ex, ALU_FUN, SEL_ALU, SEL_REG, ctrl_MEM_exe, ctrl_WB_exe,
           A, DOB_exe, imm_ext_exe, rt_exe, rd_exe,
    output stall_EX, ALU_res_mem, DOB_mem, dest_mem, ctrl_MEM_mem, ctrl_WB_mem, valid_mem
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a 32-iteration shift-add multiplier that stalls ID/EX.
// Drives the EX/MEM pipeline register.
module ex_stage (
  input  logic       reloj,
  input  logic       resetEX,
  ex_stage_if.slave  ex
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;
  logic [31:0] dob_hold_q;
  logic [4:0]  dest_hold_q;
  logic [2:0]  cmem_hold_q;
  logic [1:0]  cwb_hold_q;

  logic [31:0] res_q;
  logic [31:0] dob_q;
  logic [4:0]  dest_q;
  logic [2:0]  cmem_q;
  logic [1:0]  cwb_q;
  logic        valid_q;

  logic [31:0] op_b;
  logic [4:0]  dest;
  logic [31:0] alu_res;
  logic [31:0] partial;
  logic [31:0] acc_d;
  logic        mul_req;
  logic        last_iter;

  always_comb begin
    op_b = ex.SEL_ALU ? ex.imm_ext_exe : ex.DOB_exe;
    dest = ex.SEL_REG ? ex.rd_exe : ex.rt_exe;
    alu_res = '0;
    case (ex.ALU_FUN)
      3'b000:  alu_res = ex.A + op_b;
      3'b001:  alu_res = ex.A - op_b;
      3'b010:  alu_res = ex.A & op_b;
      3'b011:  alu_res = ex.A | op_b;
      3'b100:  alu_res = ex.A ^ op_b;
      3'b101:  alu_res = ($signed(ex.A) < $signed(op_b)) ? 32'd1 : 32'd0;
      3'b110:  alu_res = ex.A << op_b[4:0];
      default: alu_res = '0;
    endcase
  end

  // On the final iteration acc_d already includes bit 31, so it is the full product.
  assign partial   = mplier_q[cnt_q] ? (mcand_q << cnt_q) : 32'd0;
  assign acc_d     = acc_q + partial;
  assign mul_req   = ex.valid_ex & (ex.ALU_FUN == 3'b111) & ~ex.flush_EX;
  assign last_iter = (state_q == BUSY) && (cnt_q == 5'd31);

  assign ex.stall_EX = ((state_q == IDLE) & mul_req) |
                       ((state_q == BUSY) & (cnt_q != 5'd31) & ~ex.flush_EX);

  always_ff @(posedge reloj or posedge resetEX) begin
    if (resetEX) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      dob_hold_q  <= '0;
      dest_hold_q <= '0;
      cmem_hold_q <= '0;
      cwb_hold_q  <= '0;
      res_q       <= '0;
      dob_q       <= '0;
      dest_q      <= '0;
      cmem_q      <= '0;
      cwb_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      res_q   <= '0;
      dob_q   <= '0;
      dest_q  <= '0;
      cmem_q  <= '0;
      cwb_q   <= '0;
      valid_q <= 1'b0;
      if (ex.flush_EX) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        acc_q   <= '0;
      end else if (state_q == IDLE) begin
        if (mul_req) begin
          mcand_q     <= ex.A;
          mplier_q    <= op_b;
          acc_q       <= '0;
          cnt_q       <= '0;
          dob_hold_q  <= ex.DOB_exe;
          dest_hold_q <= dest;
          cmem_hold_q <= ex.ctrl_MEM_exe;
          cwb_hold_q  <= ex.ctrl_WB_exe;
          state_q     <= BUSY;
        end else if (ex.valid_ex) begin
          res_q   <= alu_res;
          dob_q   <= ex.DOB_exe;
          dest_q  <= dest;
          cmem_q  <= ex.ctrl_MEM_exe;
          cwb_q   <= ex.ctrl_WB_exe;
          valid_q <= 1'b1;
        end
      end else if (last_iter) begin
        res_q   <= acc_d;
        dob_q   <= dob_hold_q;
        dest_q  <= dest_hold_q;
        cmem_q  <= cmem_hold_q;
        cwb_q   <= cwb_hold_q;
        valid_q <= 1'b1;
        acc_q   <= '0;
        cnt_q   <= '0;
        state_q <= IDLE;
      end else begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end

  assign ex.ALU_res_mem  = res_q;
  assign ex.DOB_mem      = dob_q;
  assign ex.dest_mem     = dest_q;
  assign ex.ctrl_MEM_mem = cmem_q;
  assign ex.ctrl_WB_mem  = cwb_q;
  assign ex.valid_mem    = valid_q;

endmodule
